// File: rtl/ex_mdu.sv
// ---------------------------------------------------------------------------
// ex_mdu -- execute stage for the in-order MIPS-style pipeline.
//
// Logic, shift and move ops finish in one cycle. MULT/MULTU/DIV/DIVU run
// iteratively: an issue cycle, DATA_W BUSY cycles (shift-add multiply or
// restoring divide, one bit per cycle), then a DONE cycle that fixes up the
// signs. The HI/LO result is registered at the end of DONE. Divide by zero
// skips BUSY entirely.
//
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   aluop_i      operation encoding
//   alusel_i     result class (logic / shift / move)
//   reg1_i       operand A
//   reg2_i       operand B; the low SH_W bits are the shift amount
//   wd_i, wreg_i destination register and its write enable
//   flush_i      kills any in-flight op and inserts a bubble
//   stallreq_o   combinational stall request while a mul/div is unfinished
//   wd_o, wreg_o registered destination and write enable
//   wdata_o      registered GPR result
//   whilo_o      registered HI/LO write enable (one pulse per mul/div)
//   hi_o, lo_o   registered HI/LO result
// ---------------------------------------------------------------------------
module ex_mdu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [SEL_W-1:0]  alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = SH_W + 1;

    // Result classes
    localparam logic [SEL_W-1:0] SEL_LOGIC = SEL_W'(3'b001);
    localparam logic [SEL_W-1:0] SEL_SHIFT = SEL_W'(3'b010);
    localparam logic [SEL_W-1:0] SEL_MOVE  = SEL_W'(3'b011);

    // Operation encodings
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(8'b0010_0100);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(8'b0010_0101);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(8'b0010_0110);
    localparam logic [OP_W-1:0] OP_NOT   = OP_W'(8'b0010_0111);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8'b0111_1100);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(8'b0000_0010);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(8'b0000_0011);
    localparam logic [OP_W-1:0] OP_MOVZ  = OP_W'(8'b0000_1010);
    localparam logic [OP_W-1:0] OP_MOVN  = OP_W'(8'b0000_1011);
    localparam logic [OP_W-1:0] OP_MOV   = OP_W'(8'b0000_1100);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(8'b0001_1000);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(8'b0001_1001);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(8'b0001_1010);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(8'b0001_1011);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_is_div;
    logic                  r_neg_q;    // product / quotient must be negated
    logic                  r_neg_r;    // remainder must be negated
    logic [2*DATA_W-1:0]   r_acc;      // multiply accumulator
    logic [2*DATA_W-1:0]   r_mcand;    // multiplicand, shifted left each step
    logic [DATA_W-1:0]     r_mplier;   // multiplier, shifted right each step
    logic [DATA_W-1:0]     r_quo;      // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0]     r_rem;      // partial remainder
    logic [DATA_W-1:0]     r_dvs;      // divisor magnitude

    // ------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------
    logic                  w_is_md;
    logic                  w_is_div;
    logic                  w_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;
    logic                  w_div0;

    assign w_is_md  = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU) ||
                      (aluop_i == OP_DIV)  || (aluop_i == OP_DIVU);
    assign w_is_div = (aluop_i == OP_DIV)  || (aluop_i == OP_DIVU);
    assign w_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
    assign w_a_neg  = w_signed & reg1_i[DATA_W-1];
    assign w_b_neg  = w_signed & reg2_i[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -reg1_i : reg1_i;
    assign w_b_mag  = w_b_neg ? -reg2_i : reg2_i;
    assign w_div0   = w_is_div && (reg2_i == '0);

    assign stallreq_o = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_is_md);

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [SH_W-1:0]   w_sh;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wreg;

    assign w_sh = reg2_i[SH_W-1:0];

    always_comb begin
        w_wdata = '0;
        w_wreg  = wreg_i;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_OR:   w_wdata = reg1_i | reg2_i;
                    OP_AND:  w_wdata = reg1_i & reg2_i;
                    OP_XOR:  w_wdata = reg1_i ^ reg2_i;
                    OP_NOT:  w_wdata = ~reg1_i;
                    default: w_wdata = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  w_wdata = reg1_i << w_sh;
                    OP_SRL:  w_wdata = reg1_i >> w_sh;
                    OP_SRA:  w_wdata = $signed(reg1_i) >>> w_sh;
                    default: w_wdata = '0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_i)
                    OP_MOV:  w_wdata = reg1_i;
                    OP_MOVZ: begin
                        w_wdata = reg1_i;
                        w_wreg  = wreg_i && (reg2_i == '0);
                    end
                    OP_MOVN: begin
                        w_wdata = reg1_i;
                        w_wreg  = wreg_i && (reg2_i != '0);
                    end
                    default: w_wdata = '0;
                endcase
            end
            default: w_wdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration step and final sign fix-up
    // ------------------------------------------------------------------
    // The partial remainder is always below the divisor, so the shifted
    // value fits in DATA_W+1 bits and the difference fits in DATA_W bits.
    logic [DATA_W:0]       w_shift;
    logic                  w_ge;
    logic [DATA_W-1:0]     w_rem_next;
    logic [2*DATA_W-1:0]   w_prod_fix;
    logic [DATA_W-1:0]     w_quo_fix;
    logic [DATA_W-1:0]     w_rem_fix;

    assign w_shift    = {r_rem, r_quo[DATA_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[DATA_W-1:0] - r_dvs) : w_shift[DATA_W-1:0];

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_neg_r ? -r_rem : r_rem;

    // ------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // A flush behaves exactly like reset: the in-flight op is dropped.
        if (rst || flush_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            wd_o     <= '0;
            wreg_o   <= 1'b0;
            wdata_o  <= '0;
            whilo_o  <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            // Bubble unless a result is produced this cycle.
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
            whilo_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_md) begin
                        r_is_div <= w_is_div;
                        r_cnt    <= CNT_W'(DATA_W);
                        r_acc    <= '0;
                        r_mcand  <= {{DATA_W{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_dvs    <= w_b_mag;
                        if (w_div0) begin
                            // Result preloaded; DONE passes it through.
                            r_quo   <= '1;
                            r_rem   <= reg1_i;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_state <= S_BUSY;
                        end
                    end else begin
                        wd_o    <= wd_i;
                        wreg_o  <= w_wreg;
                        wdata_o <= w_wdata;
                    end
                end
                S_BUSY: begin
                    if (r_is_div) begin
                        r_rem <= w_rem_next;
                        r_quo <= {r_quo[DATA_W-2:0], w_ge};
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    whilo_o <= 1'b1;
                    if (r_is_div) begin
                        hi_o <= w_rem_fix;
                        lo_o <= w_quo_fix;
                    end else begin
                        hi_o <= w_prod_fix[2*DATA_W-1:DATA_W];
                        lo_o <= w_prod_fix[DATA_W-1:0];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOT   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
    localparam logic [7:0] OP_MOV   = 8'b0000_1100;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic        stallreq_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_total = 0;
    int n_bad   = 0;

    ex_mdu #(
        .DATA_W(32),
        .ADDR_W(5),
        .OP_W  (8),
        .SEL_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aluop_i   (aluop_i),
        .alusel_i  (alusel_i),
        .reg1_i    (reg1_i),
        .reg2_i    (reg2_i),
        .wd_i      (wd_i),
        .wreg_i    (wreg_i),
        .flush_i   (flush_i),
        .stallreq_o(stallreq_o),
        .wd_o      (wd_o),
        .wreg_o    (wreg_o),
        .wdata_o   (wdata_o),
        .whilo_o   (whilo_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: single-cycle result from the operation definitions.
    function automatic void model_single(input logic [7:0] op, input logic [2:0] sel,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic wr,
                                         output logic [31:0] res, output logic wro);
        int s;
        s   = int'(b % 32);
        res = 32'h0;
        wro = wr;
        if (sel == SEL_LOGIC) begin
            if (op == OP_OR)       res = a | b;
            else if (op == OP_AND) res = a & b;
            else if (op == OP_XOR) res = a ^ b;
            else if (op == OP_NOT) res = ~a;
        end else if (sel == SEL_SHIFT) begin
            if (op == OP_SLL)      res = a << s;
            else if (op == OP_SRL) res = a >> s;
            else if (op == OP_SRA) res = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
        end else if (sel == SEL_MOVE) begin
            if (op == OP_MOV) res = a;
            else if (op == OP_MOVZ) begin res = a; wro = wr && (b == 0); end
            else if (op == OP_MOVN) begin res = a; wro = wr && (b != 0); end
        end
    endfunction

    // Reference: HI/LO from 64-bit arithmetic.
    function automatic void model_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0;
        lo = 32'h0;
        if (op == OP_MULT) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == OP_MULTU) begin
            up = {32'h0, a} * {32'h0, b};
            hi = up[63:32];
            lo = up[31:0];
        end else if (b == 0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endfunction

    task automatic drive_nop();
        aluop_i  = OP_NOP;
        alusel_i = 3'b000;
        reg1_i   = 32'h0;
        reg2_i   = 32'h0;
        wd_i     = 5'd0;
        wreg_i   = 1'b0;
    endtask

    task automatic do_single(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] wd, input logic wr);
        logic [31:0] er;
        logic        ew;
        model_single(op, sel, a, b, wr, er, ew);
        @(negedge clk);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wr;
        #1;
        check_val("single_stall", stallreq_o, 0);
        @(posedge clk);
        #1;
        $display("single op=%h sel=%0d a=%h b=%h wd=%0d -> wdata=%h wreg=%0b", op, sel, a, b, wd, wdata_o, wreg_o);
        check_val("single_wdata", wdata_o, er);
        check_val("single_wreg", wreg_o, ew);
        check_val("single_wd", wd_o, wd);
        check_val("single_whilo", whilo_o, 0);
    endtask

    task automatic do_muldiv(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int cyc, exp_cyc;
        model_md(op, a, b, eh, el);
        exp_cyc = ((op == OP_DIV || op == OP_DIVU) && b == 0) ? 1 : 33;
        @(negedge clk);
        aluop_i  = op;
        alusel_i = 3'b000;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'($urandom);
        wreg_i   = 1'b1;
        cyc      = 0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                // Inputs must be ignored once the op is in flight.
                aluop_i = 8'($urandom);
                reg1_i  = $urandom;
                reg2_i  = $urandom;
                wreg_i  = 1'($urandom);
            end
            #1;
            if (!stallreq_o) break;
            cyc++;
            @(negedge clk);
        end
        check_val("md_stall_cycles", cyc, exp_cyc);
        check_val("md_whilo_early", whilo_o, 0);
        @(posedge clk);
        #1;
        $display("muldiv op=%h a=%h b=%h -> hi=%h lo=%h stall=%0d", op, a, b, hi_o, lo_o, cyc);
        check_val("md_whilo", whilo_o, 1);
        check_val("md_hi", hi_o, eh);
        check_val("md_lo", lo_o, el);
        check_val("md_wreg", wreg_o, 0);
        check_val("md_wdata", wdata_o, 0);
        @(negedge clk);
        drive_nop();
        @(posedge clk);
        #1;
        check_val("md_whilo_pulse", whilo_o, 0);
    endtask

    task automatic do_kill(input bit use_rst);
        int seen;
        @(negedge clk);
        aluop_i  = OP_MULTU;
        alusel_i = 3'b000;
        reg1_i   = $urandom;
        reg2_i   = $urandom;
        wd_i     = 5'd7;
        wreg_i   = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_val("kill_busy_stall", stallreq_o, 1);
        if (use_rst) rst = 1'b1;
        else flush_i = 1'b1;
        drive_nop();
        @(posedge clk);
        #1;
        $display("kill via %s -> wdata=%h wreg=%0b whilo=%0b stall=%0b",
                 use_rst ? "rst" : "flush", wdata_o, wreg_o, whilo_o, stallreq_o);
        check_val("kill_outputs", {wd_o, wreg_o, wdata_o, whilo_o, hi_o[0], lo_o[0]}, 0);
        check_val("kill_hilo", {hi_o, lo_o}, 0);
        check_val("kill_stall", stallreq_o, 0);
        @(negedge clk);
        rst     = 1'b0;
        flush_i = 1'b0;
        seen    = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (whilo_o) seen++;
        end
        check_val("kill_no_whilo", seen, 0);
        do_single(OP_OR, SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 1'b1);
    endtask

    logic [7:0] single_ops [11];
    logic [2:0] sels [8];
    logic [7:0] md_ops [4];

    initial begin
        single_ops = '{OP_OR, OP_AND, OP_XOR, OP_NOT, OP_SLL, OP_SRL, OP_SRA,
                       OP_MOV, OP_MOVZ, OP_MOVN, OP_NOP};
        sels   = '{SEL_LOGIC, SEL_SHIFT, SEL_MOVE, SEL_LOGIC, SEL_SHIFT, SEL_MOVE, 3'b000, 3'b110};
        md_ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

        rst     = 1'b1;
        flush_i = 1'b0;
        drive_nop();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", {wd_o, wreg_o, whilo_o}, 0);
        check_val("reset_wdata", wdata_o, 0);
        check_val("reset_hilo", {hi_o, lo_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_single(OP_OR,  SEL_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 1'b1);
        do_single(OP_SRA, SEL_SHIFT, 32'h8000_0000, 32'd4,  5'd4, 1'b1);
        do_single(OP_SRA, SEL_SHIFT, 32'h8000_0000, 32'd0,  5'd5, 1'b1);
        do_single(OP_SRL, SEL_SHIFT, 32'h8000_0000, 32'd31, 5'd6, 1'b1);
        do_single(OP_MOVZ, SEL_MOVE, 32'h0000_1234, 32'd0, 5'd8, 1'b1);
        do_single(OP_MOVZ, SEL_MOVE, 32'h0000_1234, 32'd9, 5'd8, 1'b1);
        do_single(OP_MOVN, SEL_MOVE, 32'h0000_1234, 32'd9, 5'd9, 1'b1);
        do_single(OP_OR,  3'b111,    32'h1234_5678, 32'h1, 5'd10, 1'b1);

        do_muldiv(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        do_muldiv(OP_DIVU, 32'd100, 32'd7);
        do_muldiv(OP_DIV,  32'hFFFF_FFF9, 32'd2);
        do_muldiv(OP_DIVU, 32'd5, 32'd0);
        do_muldiv(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        do_muldiv(OP_DIV,  32'hFFFF_FFF0, 32'd0);
        do_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        do_kill(1'b0);
        do_kill(1'b1);

        // Randomized single-cycle ops
        for (int i = 0; i < 150; i++) begin
            logic [31:0] b;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'h0;
            do_single(single_ops[$urandom_range(0, 10)], sels[$urandom_range(0, 7)],
                      $urandom, b, 5'($urandom), 1'($urandom));
        end

        // Randomized multi-cycle ops
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            do_muldiv(md_ops[$urandom_range(0, 3)], a, b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
